dff_fifo: RTL and testbench

- Synchronous ready/valid FIFO that buffers a Width-bit data stream between a producer and the dff stage.
- Absorbs bursts and back-pressure, and presents data to the downstream register one word per cycle.
- Sits directly upstream of the dff: the dff's input is driven from o when valid_o and ready_i are both high.

---
 rtl/dff_fifo.sv | 85 ++++++++
 tb/tb_dff_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dff_fifo.sv
// Ready/valid FIFO feeding the dff stage; head word is read combinationally from storage.
// Define DFF_FIFO_BYPASS_EN to let a word fall straight through an empty FIFO in the same cycle.
module dff_fifo #(
  parameter int Width = 4,
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [Width-1:0]           i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(Depth);

  logic [Width-1:0] mem [Depth];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic empty, full, push, pop, fall_through;

  always_comb begin
    empty = (count_reg == '0);
    full  = (count_reg == FULL_COUNT);
`ifdef DFF_FIFO_BYPASS_EN
    fall_through = empty && valid_i;
`else
    fall_through = 1'b0;
`endif
    // A fall-through word consumed in the same cycle never touches storage.
    push = valid_i && !full && !(fall_through && ready_i);
    pop  = !empty && ready_i;

    ready_o = !full;
    valid_o = !empty || fall_through;
    if (!empty)
      o = mem[rd_ptr_reg];
    else if (fall_through)
      o = i;
    else
      o = '0;
    count_o = count_reg;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push)
      wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)
      rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately left unreset; empty-state output is forced to zero above.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr_reg] <= i;
  end

endmodule

// File: tb/tb_dff_fifo.sv
// Scoreboard bench for dff_fifo: driver queues expected words, a monitor checks every pop.
module tb_dff_fifo;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [3:0] din = 4'h0;
  logic       ready_o, valid_o;
  logic [3:0] o;
  logic [2:0] count_o;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  dff_fifo #(.Width(4), .Depth(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .i       (din),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .o       (o),
    .count_o (count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end else begin
      $display("ok   %s value=%0h t=%0t", name, act, $time);
    end
  endtask

  // Called just after a rising edge: drive one cycle of inputs, then advance past the next edge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic accepted);
    valid_i = v;
    din     = d;
    ready_i = r;
    if (accepted)
      exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, a handshake on the output means the head word leaves at the next edge.
  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none t=%0t", o, $time);
      end else begin
        chk("pop_data", {28'd0, o}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {29'd0, count_o}, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_ready", {31'd0, ready_o}, 1);
    chk("rst_o", {28'd0, o}, 0);
    rst_ni = 1'b1;

    // Fill with consumer stalled.
    cycle(1, 4'h5, 0, 1);
    chk("first_o", {28'd0, o}, 5);
    chk("first_valid", {31'd0, valid_o}, 1);
    cycle(1, 4'h7, 0, 1);
    cycle(1, 4'h9, 0, 1);
    cycle(1, 4'h2, 0, 1);
    chk("full_count", {29'd0, count_o}, 4);
    chk("full_ready", {31'd0, ready_o}, 0);

    // Overflow attempts are dropped.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 4'h6, 0, 0);
      chk("ovf_count", {29'd0, count_o}, 4);
    end

    // Drain: monitor expects 5,7,9,2.
    for (int k = 0; k < 4; k++) cycle(0, 4'h0, 1, 0);
    chk("drain_count", {29'd0, count_o}, 0);
    chk("drain_valid", {31'd0, valid_o}, 0);

    // Underflow attempts.
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'h0, 1, 0);
      chk("udf_count", {29'd0, count_o}, 0);
      chk("udf_valid", {31'd0, valid_o}, 0);
    end
    chk("udf_o", {28'd0, o}, 0);
    cycle(1, 4'h3, 0, 1);
    chk("after_udf_o", {28'd0, o}, 3);
    chk("after_udf_count", {29'd0, count_o}, 1);
    cycle(0, 4'h0, 1, 0);

    // Preload two, then stream ten with simultaneous push/pop.
    cycle(1, 4'hC, 0, 1);
    cycle(1, 4'hD, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      cycle(1, 4'(k), 1, 1);
      chk("stream_count", {29'd0, count_o}, 2);
    end
    cycle(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 1, 0);
    chk("stream_end_count", {29'd0, count_o}, 0);

    // Empty FIFO, word offered with consumer ready.
    valid_i = 1'b1;
    din     = 4'h4;
    ready_i = 1'b1;
    exp_q.push_back(4'h4);
    #2;
`ifdef DFF_FIFO_BYPASS_EN
    chk("byp_valid", {31'd0, valid_o}, 1);
    chk("byp_o", {28'd0, o}, 4);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("byp_count", {29'd0, count_o}, 0);
`else
    chk("nobyp_valid", {31'd0, valid_o}, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("nobyp_o", {28'd0, o}, 4);
    chk("nobyp_valid_next", {31'd0, valid_o}, 1);
    cycle(0, 4'h0, 1, 0);
`endif
    chk("byp_end_count", {29'd0, count_o}, 0);

    // Reset mid-operation with three words stored.
    cycle(1, 4'h1, 0, 1);
    cycle(1, 4'h8, 0, 1);
    cycle(1, 4'hE, 0, 1);
    chk("pre_rst_count", {29'd0, count_o}, 3);
    valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_count", {29'd0, count_o}, 0);
    chk("async_rst_valid", {31'd0, valid_o}, 0);
    chk("async_rst_ready", {31'd0, ready_o}, 1);
    chk("async_rst_o", {28'd0, o}, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cycle(1, 4'hA, 0, 1);
    chk("post_rst_o", {28'd0, o}, 4'hA);
    chk("post_rst_valid", {31'd0, valid_o}, 1);
    cycle(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
